// File: rtl/unit_min_down_pkg.sv
// Shared definitions for the down-counting unit-minutes digit and its
// sibling digit stages: FSM state encoding, active-low 7-segment patterns
// (bit 6 = segment a ... bit 0 = segment g) and the digit range limit.
package unit_min_down_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/unit_min_down_seg7_dec.sv
// BCD to active-low 7-segment decoder, purely combinational.
// Output order is {a,b,c,d,e,f,g}; codes 10-15 blank the display.
module seg7_dec
  import unit_min_down_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Map each BCD code to its segment pattern; anything else is blank.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/unit_min_down.sv
// Unit-minutes digit of the countdown timer. Preset with INC in SET,
// counts down on TICK in RUN, holds in PAUSE, and emits a one-cycle BORROW
// on the 0->9 wrap toward the tens-of-minutes stage.
// Optional feature macro: UNIT_MIN_DOWN_STOP_EN -- when defined, a TICK at
// 0 with all lower digits zero ends the countdown (DONE pulse, back to SET)
// instead of wrapping.
module unit_min_down
  import unit_min_down_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       START,
  input  logic       INC,
  input  logic       TICK,
  input  logic       LOWER_ZERO,
  output logic       BORROW,
  output logic       DONE,
  output logic       ZERO,
  output logic [3:0] DIGIT,
  output logic       AUM,
  output logic       BUM,
  output logic       CUM,
  output logic       DUM,
  output logic       EUM,
  output logic       FUM,
  output logic       GUM
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] digit_r;
  logic [3:0] digit_nxt_s;
  logic       borrow_r;
  logic       borrow_nxt_s;
  logic       done_r;
  logic       done_nxt_s;
  logic       start_q_r;
  logic       inc_q_r;
  logic       start_edge_s;
  logic       inc_edge_s;
  logic [6:0] seg_s;

`ifndef UNIT_MIN_DOWN_STOP_EN
  // LOWER_ZERO only matters when the stop feature is built in.
  logic       unused_lower_zero_s;
  assign unused_lower_zero_s = LOWER_ZERO;
`endif

  assign start_edge_s = START & ~start_q_r;
  assign inc_edge_s   = INC & ~inc_q_r;

  // Button history; reset to 1 so a button held through reset does nothing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_q_r <= 1'b1;
      inc_q_r   <= 1'b1;
    end else begin
      start_q_r <= START;
      inc_q_r   <= INC;
    end
  end

  // Next-state, next-digit and pulse generation.
  always_comb begin
    state_nxt_s  = state_r;
    digit_nxt_s  = digit_r;
    borrow_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;
    if (CLR) begin
      state_nxt_s = ST_SET;
      digit_nxt_s = 4'd0;
    end else begin
      case (state_r)
        ST_SET: begin
          if (inc_edge_s) begin
            if (digit_r >= DIGIT_MAX) begin
              digit_nxt_s = 4'd0;
            end else begin
              digit_nxt_s = digit_r + 4'd1;
            end
          end else begin
            digit_nxt_s = digit_r;
          end
          if (start_edge_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_SET;
          end
        end
        ST_RUN: begin
          // The stop decision below overrides a simultaneous pause request.
          if (start_edge_s) begin
            state_nxt_s = ST_PAUSE;
          end else begin
            state_nxt_s = ST_RUN;
          end
          if (TICK) begin
            if (digit_r == 4'd0) begin
`ifdef UNIT_MIN_DOWN_STOP_EN
              if (LOWER_ZERO) begin
                digit_nxt_s = 4'd0;
                done_nxt_s  = 1'b1;
                state_nxt_s = ST_SET;
              end else begin
                digit_nxt_s  = DIGIT_MAX;
                borrow_nxt_s = 1'b1;
              end
`else
              digit_nxt_s  = DIGIT_MAX;
              borrow_nxt_s = 1'b1;
`endif
            end else begin
              digit_nxt_s = digit_r - 4'd1;
            end
          end else begin
            digit_nxt_s = digit_r;
          end
        end
        ST_PAUSE: begin
          if (start_edge_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end
        default: begin
          state_nxt_s = ST_SET;
          digit_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // State, digit and pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= ST_SET;
      digit_r  <= 4'd0;
      borrow_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      digit_r  <= digit_nxt_s;
      borrow_r <= borrow_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  seg7_dec u_seg7_dec (
    .bcd (digit_r),
    .seg (seg_s)
  );

  assign DIGIT  = digit_r;
  assign ZERO   = (digit_r == 4'd0);
  assign BORROW = borrow_r;
`ifdef UNIT_MIN_DOWN_STOP_EN
  assign DONE   = done_r;
`else
  assign DONE   = 1'b0;
`endif
  assign {AUM, BUM, CUM, DUM, EUM, FUM, GUM} = seg_s;

endmodule

// File: tb/tb_unit_min_down.sv
// Directed bench for unit_min_down; expectations are hand-computed and
// adapt to UNIT_MIN_DOWN_STOP_EN when the bench is built with it.
module tb_unit_min_down;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLR = 1'b0;
  logic       START = 1'b0;
  logic       INC = 1'b0;
  logic       TICK = 1'b0;
  logic       LOWER_ZERO = 1'b0;
  logic       BORROW, DONE, ZERO;
  logic [3:0] DIGIT;
  logic       AUM, BUM, CUM, DUM, EUM, FUM, GUM;
  logic [6:0] segs;

  int errors = 0;
  int checks = 0;

  assign segs = {AUM, BUM, CUM, DUM, EUM, FUM, GUM};

  unit_min_down dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .START(START), .INC(INC), .TICK(TICK),
    .LOWER_ZERO(LOWER_ZERO), .BORROW(BORROW), .DONE(DONE), .ZERO(ZERO),
    .DIGIT(DIGIT), .AUM(AUM), .BUM(BUM), .CUM(CUM), .DUM(DUM), .EUM(EUM),
    .FUM(FUM), .GUM(GUM)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1; step(); START = 1'b0; step();
  endtask

  task automatic pulse_inc();
    INC = 1'b1; step(); INC = 1'b0; step();
  endtask

  initial begin
    // Reset with START and INC held high.
    START = 1'b1; INC = 1'b1;
    step(); step();
    chk("rst_digit", DIGIT, 4'd0);
    chk("rst_zero", ZERO, 1'b1);
    chk("rst_segs", segs, 7'b0000001);
    chk("rst_borrow", BORROW, 1'b0);
    chk("rst_done", DONE, 1'b0);
    RST = 1'b0;
    step(); step(); step();
    chk("held_inc_through_reset", DIGIT, 4'd0);
    START = 1'b0; INC = 1'b0; step();
    // Held START gave no edge: still SET, so TICK is ignored.
    TICK = 1'b1; step(); TICK = 1'b0; step();
    chk("held_start_no_run", DIGIT, 4'd0);

    // INC held 20 cycles advances by exactly one.
    INC = 1'b1;
    repeat (20) step();
    chk("inc_held_20", DIGIT, 4'd1);
    INC = 1'b0; step();

    // Fresh reset, 3 INC edges, run, 4 ticks: 3->2->1->0->9.
    RST = 1'b1; step(); RST = 1'b0; step();
    chk("rst2_digit", DIGIT, 4'd0);
    pulse_inc(); pulse_inc(); pulse_inc();
    chk("inc3", DIGIT, 4'd3);
    chk("seg3", segs, 7'b0000110);
    pulse_start();
    TICK = 1'b1;
    step(); chk("tick1_digit", DIGIT, 4'd2); chk("tick1_borrow", BORROW, 1'b0);
    step(); chk("tick2_digit", DIGIT, 4'd1); chk("tick2_borrow", BORROW, 1'b0);
    step(); chk("tick3_digit", DIGIT, 4'd0); chk("tick3_zero", ZERO, 1'b1);
    chk("tick3_borrow", BORROW, 1'b0);
    step(); chk("tick4_digit", DIGIT, 4'd9); chk("tick4_borrow", BORROW, 1'b1);
    chk("seg9", segs, 7'b0000100); chk("tick4_zero", ZERO, 1'b0);
    TICK = 1'b0;
    step(); chk("borrow_one_cycle", BORROW, 1'b0); chk("hold9", DIGIT, 4'd9);

    // INC ignored in RUN.
    pulse_inc();
    chk("inc_ignored_run", DIGIT, 4'd9);

    // Down to 5, then TICK + START edge together.
    TICK = 1'b1; repeat (4) step(); TICK = 1'b0;
    chk("down_to_5", DIGIT, 4'd5);
    chk("seg5", segs, 7'b0100100);
    TICK = 1'b1; START = 1'b1; step();
    chk("tick_and_pause", DIGIT, 4'd4);
    START = 1'b0; step();
    chk("pause_ignores_tick", DIGIT, 4'd4);
    TICK = 1'b0; pulse_inc();
    chk("pause_ignores_inc", DIGIT, 4'd4);
    pulse_start();
    TICK = 1'b1; step(); TICK = 1'b0;
    chk("resume_tick", DIGIT, 4'd3);

    // Count down to 7 (3,2,1,0,9,8,7), then CLR with TICK.
    TICK = 1'b1; repeat (6) step(); TICK = 1'b0;
    chk("down_to_7", DIGIT, 4'd7);
    CLR = 1'b1; TICK = 1'b1; step();
    chk("clr_digit", DIGIT, 4'd0); chk("clr_borrow", BORROW, 1'b0);
    CLR = 1'b0; step();
    TICK = 1'b0;
    chk("clr_set_ignores_tick", DIGIT, 4'd0);
    pulse_inc();
    chk("clr_set_inc", DIGIT, 4'd1);

    // End-of-countdown with LOWER_ZERO=1.
    CLR = 1'b1; step(); CLR = 1'b0; step();
    pulse_start();
    LOWER_ZERO = 1'b1; TICK = 1'b1; step(); TICK = 1'b0;
`ifdef UNIT_MIN_DOWN_STOP_EN
    chk("stop_done", DONE, 1'b1); chk("stop_digit", DIGIT, 4'd0);
    chk("stop_borrow", BORROW, 1'b0);
    step(); chk("stop_done_one_cycle", DONE, 1'b0);
    TICK = 1'b1; step(); TICK = 1'b0;
    chk("stop_in_set", DIGIT, 4'd0);
`else
    chk("nostop_done", DONE, 1'b0); chk("nostop_digit", DIGIT, 4'd9);
    chk("nostop_borrow", BORROW, 1'b1);
    step(); chk("nostop_done_later", DONE, 1'b0);
`endif

    // LOWER_ZERO=0 always wraps.
    CLR = 1'b1; step(); CLR = 1'b0; step();
    pulse_start();
    LOWER_ZERO = 1'b0; TICK = 1'b1; step(); TICK = 1'b0;
    chk("lz0_digit", DIGIT, 4'd9); chk("lz0_borrow", BORROW, 1'b1);
    chk("lz0_done", DONE, 1'b0);

    // Asynchronous reset mid-count while a wrap pulse is pending.
    TICK = 1'b1; repeat (9) step();
    chk("pre_rst_digit", DIGIT, 4'd0);
    #1 RST = 1'b1; #1;
    chk("async_rst_digit", DIGIT, 4'd0);
    chk("async_rst_borrow", BORROW, 1'b0);
    step();
    chk("rst_hold_borrow", BORROW, 1'b0);
    chk("rst_hold_digit", DIGIT, 4'd0);
    TICK = 1'b0; RST = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
